// File: rtl/dec_scan_if.sv
// Handshake bundle between a scan controller (master) and the dec_scan_sequencer (slave).
interface dec_scan_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  localparam int NCH = 1 << SEL_W;

  logic               start;
  logic               stop;
  logic               cont;
  logic [NCH-1:0]     mask;
  logic [DWELL_W-1:0] dwell;
  logic [SEL_W-1:0]   sel;
  logic               enable;
  logic               busy;
  logic               done;

  modport master (output start, stop, cont, mask, dwell,
                  input  sel, enable, busy, done);
  modport slave  (input  start, stop, cont, mask, dwell,
                  output sel, enable, busy, done);
endinterface

// File: rtl/dec_scan_sequencer.sv
// Sweeps decoder8 select over a channel mask with per-channel dwell and
// break-before-make switching (OFF drops enable, SWITCH moves sel).
module dec_scan_sequencer #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  dec_scan_if.slave bus
);
  localparam int NCH = 1 << SEL_W;

  typedef enum logic [1:0] {IDLE, ACTIVE, OFF, SWITCH} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pend_q, pend_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cont_q, cont_d;

  // {found, index} of the lowest set bit of m at or above position from
  function automatic logic [SEL_W:0] lowest_from(input logic [NCH-1:0] m,
                                                 input logic [SEL_W:0] from);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i] && i >= int'(from)) r = {1'b1, i[SEL_W-1:0]};
    return r;
  endfunction

  logic [SEL_W:0] sel_inc, next_w, first_w, load_w;

  assign sel_inc = {1'b0, sel_q} + (SEL_W+1)'(1);
  assign next_w  = lowest_from(mask_q, sel_inc);
  assign first_w = lowest_from(mask_q, '0);
  assign load_w  = lowest_from(bus.mask, '0);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;

    if (busy_q && bus.stop) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          mask_d  = bus.mask;
          dwell_d = bus.dwell;
          cont_d  = bus.cont;
          if (bus.mask == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ACTIVE;
            sel_d   = load_w[SEL_W-1:0];
            en_d    = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = bus.dwell;
          end
        end
      end
      ACTIVE: begin
        if (cnt_q == '0) begin
          state_d = OFF;
          en_d    = 1'b0;
          // done is registered, so the OFF-cycle decision is made here; a stop
          // arriving this cycle is already pending by the time OFF acts on it
          done_d  = !next_w[SEL_W] || pend_q || bus.stop;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      OFF: begin
        if (next_w[SEL_W] && !pend_q) begin
          state_d = SWITCH;
          sel_d   = next_w[SEL_W-1:0];
        end else if (!next_w[SEL_W] && cont_q && !pend_q) begin
          state_d = SWITCH;
          sel_d   = first_w[SEL_W-1:0];
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          pend_d  = 1'b0;
        end
      end
      SWITCH: begin
        state_d = ACTIVE;
        en_d    = 1'b1;
        cnt_d   = dwell_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
    end
  end

  assign bus.sel    = sel_q;
  assign bus.enable = en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_dec_scan_sequencer.sv
// Scoreboard bench: directed sweeps push expected channel/done/busy-fall events,
// a negedge monitor turns DUT activity into events and compares in order.
module tb_dec_scan_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dec_scan_if #(.SEL_W(3), .DWELL_W(8)) ifc ();

  dec_scan_sequencer #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // kind 0: channel window {sel, enabled cycles, preceding busy gap, decoder out}
  // kind 1: done pulse {busy during pulse, busy cycles since previous done}
  // kind 2: busy falling
  typedef struct {
    int kind; int sel; int len; int gap; int dec; int bsy; int per;
  } ev_t;

  ev_t exp_q[$];

  function automatic ev_t mk(int kind, int sel, int len, int gap, int dec, int bsy, int per);
    ev_t e;
    e.kind = kind; e.sel = sel; e.len = len; e.gap = gap;
    e.dec = dec; e.bsy = bsy; e.per = per;
    return e;
  endfunction

  task automatic exp_ch(int sel, int len, int gap, int dec);
    exp_q.push_back(mk(0, sel, len, gap, dec, 0, 0));
  endtask
  task automatic exp_done(int bsy, int per);
    exp_q.push_back(mk(1, 0, 0, 0, 0, bsy, per));
  endtask
  task automatic exp_fall();
    exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic compare(ev_t got);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d sel=%0d len=%0d gap=%0d dec=%02h busy=%0d per=%0d, required none",
               got.kind, got.sel, got.len, got.gap, got.dec, got.bsy, got.per);
    end else begin
      e = exp_q.pop_front();
      if (got != e) begin
        failures++;
        $display("FAIL event: got kind=%0d sel=%0d len=%0d gap=%0d dec=%02h busy=%0d per=%0d, required kind=%0d sel=%0d len=%0d gap=%0d dec=%02h busy=%0d per=%0d",
                 got.kind, got.sel, got.len, got.gap, got.dec, got.bsy, got.per,
                 e.kind, e.sel, e.len, e.gap, e.dec, e.bsy, e.per);
      end
    end
  endtask

  task automatic check(string name, int got, int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Monitor
  initial begin
    int run_len, gap_cnt, per_cnt, cur_sel, cur_gap, cur_dec, dec;
    logic prev_en, prev_busy;
    logic [2:0] prev_sel;
    run_len = 0; gap_cnt = 0; per_cnt = 0; cur_sel = 0; cur_gap = 0; cur_dec = 0;
    prev_en = 1'b0; prev_busy = 1'b0; prev_sel = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_len = 0; gap_cnt = 0; per_cnt = 0;
        prev_en = 1'b0; prev_busy = 1'b0; prev_sel = '0;
      end else begin
        dec = ifc.enable ? (1 << ifc.sel) : 0;
        // sel must already be settled whenever enable is high mid-sweep
        if (ifc.enable && prev_busy) begin
          checks++;
          if (ifc.sel != prev_sel) begin
            failures++;
            $display("FAIL sel_stable: sel %0d with enable high, previous sel %0d", ifc.sel, prev_sel);
          end
        end
        if (ifc.busy) per_cnt++;
        if (ifc.enable) begin
          if (!prev_en) begin
            cur_sel = ifc.sel; cur_gap = gap_cnt; cur_dec = dec; gap_cnt = 0;
          end
          run_len++;
        end else begin
          if (prev_en) compare(mk(0, cur_sel, run_len, cur_gap, cur_dec, 0, 0));
          run_len = 0;
          gap_cnt = ifc.busy ? gap_cnt + 1 : 0;
        end
        if (ifc.done) begin
          compare(mk(1, 0, 0, 0, 0, int'(ifc.busy), per_cnt));
          per_cnt = 0;
        end
        if (prev_busy && !ifc.busy) compare(mk(2, 0, 0, 0, 0, 0, 0));
        prev_en = ifc.enable; prev_busy = ifc.busy; prev_sel = ifc.sel;
      end
    end
  end

  task automatic start_sweep(logic [7:0] m, logic [7:0] d, logic c);
    @(posedge clk); #1;
    ifc.mask = m; ifc.dwell = d; ifc.cont = c; ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
  endtask

  task automatic drain(string name, int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ifc.busy) && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) begin
      checks++; failures++;
      $display("FAIL %s_timeout: %0d events still pending, required 0", name, exp_q.size());
    end
    repeat (8) @(negedge clk);
    check({name, "_idle_busy"}, int'(ifc.busy), 0);
    check({name, "_queue"}, exp_q.size(), 0);
  endtask

  task automatic wait_neg(string name, int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (ifc.enable && ifc.sel == 3'd4) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL %s_timeout: channel 4 never enabled, required enabled", name);
    end
  endtask

  initial begin
    bit ok;
    int dn;
    ifc.start = 1'b0; ifc.stop = 1'b0; ifc.cont = 1'b0; ifc.mask = '0; ifc.dwell = '0;
    #1;
    check("reset_sel", int'(ifc.sel), 0);
    check("reset_enable", int'(ifc.enable), 0);
    check("reset_busy", int'(ifc.busy), 0);
    check("reset_done", int'(ifc.done), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: reset in the middle of channel 0's 6-cycle dwell; no events expected
    start_sweep(8'hFF, 8'd5, 1'b0);
    repeat (3) @(posedge clk);
    check("pre_reset_enable", int'(ifc.enable), 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_sel", int'(ifc.sel), 0);
    check("async_rst_enable", int'(ifc.enable), 0);
    check("async_rst_busy", int'(ifc.busy), 0);
    check("async_rst_done", int'(ifc.done), 0);
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_enable", int'(ifc.enable), 0);
    drain("t1", 50);

    // 2: single sweep 0,2,5,7 x 3 cycles; busy = 4*3 enabled + 3 OFF/SWITCH pairs + final OFF = 19
    exp_ch(0, 3, 0, 8'h01); exp_ch(2, 3, 2, 8'h04);
    exp_ch(5, 3, 2, 8'h20); exp_ch(7, 3, 2, 8'h80);
    exp_done(1, 19); exp_fall();
    start_sweep(8'hA5, 8'd2, 1'b0);
    drain("t2", 100);

    // 3: continuous 0,7 wrap, done every 6; stop issued in the SWITCH after 3rd done
    exp_ch(0, 1, 0, 8'h01); exp_ch(7, 1, 2, 8'h80); exp_done(1, 5);
    exp_ch(0, 1, 2, 8'h01); exp_ch(7, 1, 2, 8'h80); exp_done(1, 6);
    exp_ch(0, 1, 2, 8'h01); exp_ch(7, 1, 2, 8'h80); exp_done(1, 6);
    exp_ch(0, 1, 2, 8'h01); exp_done(1, 3); exp_fall();
    start_sweep(8'h81, 8'd0, 1'b1);
    dn = 0;
    for (int n = 0; n < 100 && dn < 3; n++) begin
      @(negedge clk);
      if (ifc.done) dn++;
    end
    check("t3_done_count", dn, 3);
    @(posedge clk); #1 ifc.stop = 1'b1;
    @(posedge clk); #1 ifc.stop = 1'b0;
    drain("t3", 100);

    // 4: graceful stop in the 2nd cycle of channel 4; channel 5 never enabled
    exp_ch(0, 4, 0, 8'h01); exp_ch(1, 4, 2, 8'h02); exp_ch(2, 4, 2, 8'h04);
    exp_ch(3, 4, 2, 8'h08); exp_ch(4, 4, 2, 8'h10);
    exp_done(1, 29); exp_fall();
    start_sweep(8'hFF, 8'd3, 1'b1);
    wait_neg("t4", 100, ok);
    @(posedge clk); #1 ifc.stop = 1'b1;
    @(posedge clk); #1 ifc.stop = 1'b0;
    drain("t4", 100);

    // 5a: empty mask -> lone done, no busy
    exp_done(0, 0);
    start_sweep(8'h00, 8'd4, 1'b0);
    drain("t5a", 50);

    // 5b: restart and input changes mid-sweep are ignored
    exp_ch(1, 2, 0, 8'h02); exp_ch(2, 2, 2, 8'h04); exp_done(1, 7); exp_fall();
    start_sweep(8'h06, 8'd1, 1'b0);
    ifc.start = 1'b1; ifc.mask = 8'hFF; ifc.dwell = 8'd7; ifc.cont = 1'b1;
    @(posedge clk); #1 ifc.start = 1'b0;
    drain("t5b", 50);

    // 5c: start with stop in IDLE does nothing
    @(posedge clk); #1 ifc.start = 1'b1; ifc.stop = 1'b1;
    @(posedge clk); #1 ifc.start = 1'b0; ifc.stop = 1'b0;
    repeat (4) @(negedge clk);
    check("t5c_busy", int'(ifc.busy), 0);
    check("t5c_enable", int'(ifc.enable), 0);
    drain("t5c", 20);

    // 6: dwell all-ones holds channel 4 for 256 cycles
    exp_ch(4, 256, 0, 8'h10); exp_done(1, 257); exp_fall();
    start_sweep(8'h10, 8'hFF, 1'b0);
    drain("t6", 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
